// File: rtl/apb_regbank_completer.sv
// Purpose: APB completer exposing NUM_REGS registers; the top index is a read-only completed-transfer counter.
// Latency: setup at cycle T -> PREADY high in cycle T+1+WAIT_CYCLES (WAIT_CYCLES=0 gives zero-wait).
// Backpressure: PREADY is held low for WAIT_CYCLES access cycles; dropping PSEL mid-access aborts cleanly.
//
// Ports:
//   PCLK, PRESETN         clock (rising edge), asynchronous active-low reset
//   PSEL, PENABLE, PWRITE APB control from the leader
//   PADDR, PWDATA         register index (word address) and write data
//   PRDATA, PREADY,       registered response; PRDATA/PSLVERR are non-zero only
//   PSLVERR               in the single PREADY=1 cycle
module apb_regbank_completer #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int                  IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH:0] LP_NUM_REGS = (ADDR_WIDTH+1)'(NUM_REGS);
    localparam logic [ADDR_WIDTH:0] LP_LAST     = (ADDR_WIDTH+1)'(NUM_REGS - 1);
    localparam logic [3:0]          LP_WAIT     = 4'(WAIT_CYCLES);
    localparam logic [DATA_WIDTH-1:0] LP_ONE    = DATA_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_wait_cnt;
    logic [3:0]            w_wait_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic                  r_pready;
    logic                  r_pslverr;
    logic [DATA_WIDTH-1:0] r_prdata;

    logic                  w_latch;
    logic                  w_commit;
    logic                  w_pready_nxt;
    logic                  w_pslverr_nxt;
    logic [DATA_WIDTH-1:0] w_prdata_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_sel;
    logic                  w_write_sel;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] w_rd_val;

    // In IDLE the response may be produced straight from the bus (zero-wait case);
    // otherwise the latched copy is used so a wandering PADDR cannot corrupt the access.
    assign w_addr_sel  = (r_state == S_IDLE) ? PADDR  : r_addr;
    assign w_write_sel = (r_state == S_IDLE) ? PWRITE : r_write;
    assign w_err       = ({1'b0, w_addr_sel} >= LP_NUM_REGS) |
                         (w_write_sel & ({1'b0, w_addr_sel} == LP_LAST));
    assign w_rd_val    = (w_err | w_write_sel) ? '0 : r_regs[w_addr_sel[IDX_W-1:0]];

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_pready   <= 1'b0;
            r_pslverr  <= 1'b0;
            r_prdata   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_pready   <= w_pready_nxt;
            r_pslverr  <= w_pslverr_nxt;
            r_prdata   <= w_prdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait_cnt;
        w_latch       = 1'b0;
        w_commit      = 1'b0;
        w_pready_nxt  = 1'b0;
        w_pslverr_nxt = 1'b0;
        w_prdata_nxt  = '0;
        case (r_state)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_latch    = 1'b1;
                    w_wait_nxt = LP_WAIT;
                    if (LP_WAIT == 4'd0) begin
                        w_state_nxt   = S_DONE;
                        w_pready_nxt  = 1'b1;
                        w_pslverr_nxt = w_err;
                        w_prdata_nxt  = w_rd_val;
                    end else begin
                        w_state_nxt = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (!PSEL) begin
                    w_state_nxt = S_IDLE;
                end else if (r_wait_cnt > 4'd1) begin
                    w_wait_nxt = r_wait_cnt - 4'd1;
                end else begin
                    // Last wait cycle: raise PREADY for the following cycle.
                    w_state_nxt   = S_DONE;
                    w_pready_nxt  = 1'b1;
                    w_pslverr_nxt = w_err;
                    w_prdata_nxt  = w_rd_val;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_commit    = PSEL & PENABLE & ~r_pslverr;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
        end else if (w_latch) begin
            r_addr  <= PADDR;
            r_write <= PWRITE;
            r_wdata <= PWDATA;
        end
    end

    // Writes to the counter index are always errored, so the data write and the
    // counter increment never target the same entry.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            if (r_write) begin
                r_regs[r_addr[IDX_W-1:0]] <= r_wdata;
            end
            r_regs[NUM_REGS-1] <= r_regs[NUM_REGS-1] + LP_ONE;
        end
    end

    assign PREADY  = r_pready;
    assign PSLVERR = r_pslverr;
    assign PRDATA  = r_prdata;

endmodule

// File: tb/tb_apb_regbank_completer.sv
// Purpose: self-checking bench for apb_regbank_completer using three instances
// (WAIT=2/16 regs, WAIT=0/16 regs, WAIT=1/4 regs x 8 bits) against a register-array model.
module tb_apb_regbank_completer;

    logic        PCLK = 1'b0;
    logic        PRESETN = 1'b0;
    logic        psel0 = 1'b0, psel1 = 1'b0, psel2 = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [9:0]  PADDR = '0;
    logic [15:0] PWDATA = '0;
    logic [15:0] prdata0, prdata1;
    logic [7:0]  prdata2;
    logic        pready0, pready1, pready2;
    logic        pslverr0, pslverr1, pslverr2;

    int n_checks = 0;
    int n_fail   = 0;

    int          WC [3] = '{2, 0, 1};
    int          NR [3] = '{16, 16, 4};
    logic [15:0] mem [3][16];
    logic [15:0] cnt [3];

    always #5 PCLK = ~PCLK;

    apb_regbank_completer #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .NUM_REGS(16), .WAIT_CYCLES(2)) u0 (
        .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(psel0), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0));
    apb_regbank_completer #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .NUM_REGS(16), .WAIT_CYCLES(0)) u1 (
        .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(psel1), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1));
    apb_regbank_completer #(.ADDR_WIDTH(10), .DATA_WIDTH(8), .NUM_REGS(4), .WAIT_CYCLES(1)) u2 (
        .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(psel2), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA[7:0]), .PRDATA(prdata2), .PREADY(pready2), .PSLVERR(pslverr2));

    function automatic logic get_pready(input int d);
        case (d)
            0:       return pready0;
            1:       return pready1;
            default: return pready2;
        endcase
    endfunction

    function automatic logic get_pslverr(input int d);
        case (d)
            0:       return pslverr0;
            1:       return pslverr1;
            default: return pslverr2;
        endcase
    endfunction

    function automatic logic [15:0] get_prdata(input int d);
        case (d)
            0:       return prdata0;
            1:       return prdata1;
            default: return {8'h00, prdata2};
        endcase
    endfunction

    function automatic logic [15:0] msk(input int d);
        return (d == 2) ? 16'h00FF : 16'hFFFF;
    endfunction

    task automatic set_psel(input int d, input logic v);
        case (d)
            0:       psel0 = v;
            1:       psel1 = v;
            default: psel2 = v;
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            cnt[d] = '0;
            for (int i = 0; i < 16; i++) mem[d][i] = '0;
        end
    endtask

    task automatic do_reset();
        PRESETN = 1'b0;
        psel0 = 1'b0; psel1 = 1'b0; psel2 = 1'b0;
        PENABLE = 1'b0;
        model_reset();
        tick();
        PRESETN = 1'b1;
    endtask

    task automatic check_quiet(input int d, input string tag);
        check({tag, "_pready"},  32'(get_pready(d)),  32'd0);
        check({tag, "_pslverr"}, 32'(get_pslverr(d)), 32'd0);
        check({tag, "_prdata"},  32'(get_prdata(d)),  32'd0);
    endtask

    // One complete APB transfer; expected response computed from the register model.
    // Called #1 after a rising edge; returns #1 after the commit edge with the bus idle.
    task automatic xfer(input int d, input logic wr, input logic [9:0] addr,
                        input logic [15:0] wdata, input logic scramble);
        int          n, lat;
        logic        got, exp_err;
        logic [15:0] exp_rd;
        n       = NR[d];
        exp_err = (int'(addr) >= n) || (wr && int'(addr) == n - 1);
        exp_rd  = '0;
        if (!exp_err && !wr)
            exp_rd = (int'(addr) == n - 1) ? cnt[d] : mem[d][addr[3:0]];
        set_psel(d, 1'b1);
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = wdata;
        tick();
        PENABLE = 1'b1;
        if (scramble) begin
            PADDR  = ~addr;
            PWDATA = ~wdata;
        end
        lat = 0;
        got = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (get_pready(d)) begin
                lat = c;
                got = 1'b1;
                break;
            end
            check("wait_prdata",  32'(get_prdata(d)),  32'd0);
            check("wait_pslverr", 32'(get_pslverr(d)), 32'd0);
            tick();
        end
        check("pready_timeout", 32'(got), 32'd1);
        if (got) begin
            check("latency", 32'(lat), 32'(WC[d] + 1));
            check("prdata",  32'(get_prdata(d)),  32'(exp_rd));
            check("pslverr", 32'(get_pslverr(d)), 32'(exp_err));
        end
        tick();
        set_psel(d, 1'b0);
        PENABLE = 1'b0;
        check("pready_one_cycle", 32'(get_pready(d)), 32'd0);
        if (got && !exp_err) begin
            if (wr) mem[d][addr[3:0]] = wdata & msk(d);
            cnt[d] = (cnt[d] + 16'd1) & msk(d);
        end
    endtask

    task automatic rand_xfer(input int d, input int max_addr);
        xfer(d, 1'($urandom_range(0, 1)), 10'($urandom_range(0, max_addr)),
             16'($urandom), 1'($urandom_range(0, 1)));
        repeat ($urandom_range(0, 2)) tick();
    endtask

    initial begin
        int guard;
        model_reset();
        #2;
        for (int d = 0; d < 3; d++) check_quiet(d, "reset");
        tick();
        PRESETN = 1'b1;
        tick();

        // Reset asserted mid-ACCESS of a read, then register must be cleared.
        xfer(0, 1'b1, 10'd3, 16'hBEEF, 1'b0);
        psel0 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 10'd3;
        tick();
        PENABLE = 1'b1;
        tick();
        PRESETN = 1'b0;
        #1;
        check_quiet(0, "rst_mid_access");
        tick();
        do_reset();
        xfer(0, 1'b0, 10'd3, 16'h0000, 1'b0);

        // Reset asserted during the PREADY cycle clears the response immediately.
        xfer(0, 1'b1, 10'd3, 16'hBEEF, 1'b0);
        psel0 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 10'd3;
        tick();
        PENABLE = 1'b1;
        tick();
        tick();
        check("rst_pre_pready", 32'(pready0), 32'd1);
        check("rst_pre_prdata", 32'(prdata0), 32'h0000BEEF);
        PRESETN = 1'b0;
        #1;
        check_quiet(0, "rst_in_pready");
        tick();
        do_reset();
        xfer(0, 1'b0, 10'd3, 16'h0000, 1'b0);
        do_reset();

        // Write/read with two wait states, then counter reads 2.
        xfer(0, 1'b1, 10'd3, 16'hBEEF, 1'b0);
        xfer(0, 1'b0, 10'd3, 16'h0000, 1'b0);
        xfer(0, 1'b0, 10'd15, 16'h0000, 1'b0);
        check("xfer_cnt_model", 32'(cnt[0]), 32'd3);

        // Zero-wait, back-to-back with no idle cycle.
        xfer(1, 1'b1, 10'd1, 16'h0001, 1'b0);
        xfer(1, 1'b0, 10'd1, 16'h0000, 1'b0);

        // Error cases leave counter unchanged.
        xfer(0, 1'b0, 10'd20, 16'h0000, 1'b0);
        xfer(0, 1'b1, 10'd15, 16'h1234, 1'b0);
        xfer(0, 1'b0, 10'd15, 16'h0000, 1'b0);

        // Abort: PSEL dropped after one access cycle of a write.
        psel0 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 10'd2; PWDATA = 16'h5555;
        tick();
        PENABLE = 1'b1;
        tick();
        psel0 = 1'b0; PENABLE = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("abort_no_pready", 32'(pready0), 32'd0);
            tick();
        end
        xfer(0, 1'b0, 10'd2, 16'h0000, 1'b0);
        xfer(0, 1'b0, 10'd15, 16'h0000, 1'b0);

        // PENABLE high in IDLE without a setup phase is ignored.
        psel0 = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 10'd4; PWDATA = 16'hAAAA;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_setup_pready", 32'(pready0), 32'd0);
        end
        psel0 = 1'b0; PENABLE = 1'b0;
        tick();
        xfer(0, 1'b0, 10'd4, 16'h0000, 1'b0);

        // Address/data changed during ACCESS must not affect the access.
        xfer(0, 1'b1, 10'd5, 16'h1357, 1'b1);
        xfer(0, 1'b0, 10'd5, 16'h0000, 1'b1);
        xfer(1, 1'b1, 10'd6, 16'h2468, 1'b1);
        xfer(1, 1'b0, 10'd6, 16'h0000, 1'b1);

        // Randomized traffic on all three instances.
        for (int k = 0; k < 120; k++) rand_xfer(0, 19);
        for (int k = 0; k < 60; k++)  rand_xfer(1, 19);
        for (int k = 0; k < 40; k++)  rand_xfer(2, 6);
        xfer(0, 1'b0, 10'd15, 16'h0000, 1'b0);
        xfer(1, 1'b0, 10'd15, 16'h0000, 1'b0);

        // Counter wrap on the 8-bit instance: reads of 0xFF then 0x00.
        guard = 0;
        while (cnt[2] != 16'h00FF && guard < 600) begin
            xfer(2, 1'b0, 10'd0, 16'h0000, 1'b0);
            guard++;
        end
        check("wrap_reach", 32'(cnt[2]), 32'h000000FF);
        xfer(2, 1'b0, 10'd3, 16'h0000, 1'b0);
        check("wrap_model", 32'(cnt[2]), 32'd0);
        xfer(2, 1'b0, 10'd3, 16'h0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
